// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the RISC-V pipeline control blocks.
package riscv_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [4:0] REG_X0     = 5'd0;
    localparam int         WAIT_CNT_W = 8;

endpackage

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the operands read in ID.
module load_use_detect
    import riscv_ctrl_pkg::*;
(
    input  logic [4:0] rs1_ID,
    input  logic [4:0] rs2_ID,
    input  logic       use_rs1_ID,
    input  logic       use_rs2_ID,
    input  logic       MemRead_EX,
    input  logic [4:0] RD_EX,
    output logic       loaduse
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = use_rs1_ID && (rs1_ID == RD_EX);
    assign rs2_hit = use_rs2_ID && (rs2_ID == RD_EX);

    // x0 is hard-wired to zero, so a load targeting it never creates a dependency
    assign loaduse = MemRead_EX && (RD_EX != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: load-use, taken branch and data-memory wait handling,
// with a memory-wait watchdog and a saturating stall-cycle counter.
module hazard_stall_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             use_rs1_ID,
    input  logic             use_rs2_ID,
    input  logic             MemRead_EX,
    input  logic [4:0]       RD_EX,
    input  logic             branch_taken_EX,
    input  logic             mem_op_MEM,
    input  logic             dmem_ready,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             ID_EX_write,
    output logic             EX_MEM_write,
    output logic             MEM_WB_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             MEM_WB_flush,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

    state_t                state;
    state_t                state_nxt;
    state_t                eff_state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [WAIT_CNT_W-1:0] wait_cnt_nxt;
    logic                  loaduse;
    logic                  memstall;
    logic                  stall_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    load_use_detect u_load_use_detect (
        .rs1_ID     (rs1_ID),
        .rs2_ID     (rs2_ID),
        .use_rs1_ID (use_rs1_ID),
        .use_rs2_ID (use_rs2_ID),
        .MemRead_EX (MemRead_EX),
        .RD_EX      (RD_EX),
        .loaduse    (loaduse)
    );

    // While reset is held the outputs decode as RUN, whatever the register holds
    assign eff_state = reset ? RUN : state;

    assign memstall = ((eff_state == RUN) && mem_op_MEM && !dmem_ready) ||
                      ((eff_state == MEM_WAIT) && !dmem_ready);

    assign stall_inc = (eff_state != ERROR) &&
                       (memstall || (loaduse && !branch_taken_EX));

    assign mem_error = (eff_state == ERROR);

    always_comb begin
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_write  = 1'b1;
        EX_MEM_write = 1'b1;
        MEM_WB_write = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        MEM_WB_flush = 1'b0;
        if (eff_state == ERROR) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_write = 1'b0;
        end else if (memstall) begin
            // Freeze everything; branch/load-use inputs stay stable and are acted on at release
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_write = 1'b0;
            MEM_WB_flush = 1'b1;
        end else if (branch_taken_EX) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (loaduse) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (mem_op_MEM && !dmem_ready) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WAIT_CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_CNT_W'(1);
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt = ERROR;
                    end
                end
            end
            ERROR: begin
                state_nxt = ERROR;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            wait_cnt     <= '0;
            stall_cycles <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (stall_inc) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: vector table, hand sequences and random stimulus vs model.
module tb_hazard_stall_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB writes, IF_ID, ID_EX, MEM_WB flushes}
    localparam logic [7:0] C_NORM  = 8'b11111_000;
    localparam logic [7:0] C_LU    = 8'b00111_010;
    localparam logic [7:0] C_BR    = 8'b11111_110;
    localparam logic [7:0] C_MEM   = 8'b00000_001;
    localparam logic [7:0] C_ERR   = 8'b00000_000;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       rs1_ID, rs2_ID, RD_EX;
    logic             use_rs1_ID, use_rs2_ID, MemRead_EX;
    logic             branch_taken_EX, mem_op_MEM, dmem_ready;
    logic             PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write;
    logic             IF_ID_flush, ID_EX_flush, MEM_WB_flush, mem_error;
    logic [CNT_W-1:0] stall_cycles;
    logic [7:0]       ctl;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    bit m_err;
    bit m_out;
    int m_consec;
    int m_stall;

    logic [7:0]       last_ctl;
    logic [CNT_W-1:0] last_stall;
    logic             last_merr;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       mop;
        logic       rdy;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    assign ctl = {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write,
                  IF_ID_flush, ID_EX_flush, MEM_WB_flush};

    hazard_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .rs1_ID          (rs1_ID),
        .rs2_ID          (rs2_ID),
        .use_rs1_ID      (use_rs1_ID),
        .use_rs2_ID      (use_rs2_ID),
        .MemRead_EX      (MemRead_EX),
        .RD_EX           (RD_EX),
        .branch_taken_EX (branch_taken_EX),
        .mem_op_MEM      (mem_op_MEM),
        .dmem_ready      (dmem_ready),
        .PC_write        (PC_write),
        .IF_ID_write     (IF_ID_write),
        .ID_EX_write     (ID_EX_write),
        .EX_MEM_write    (EX_MEM_write),
        .MEM_WB_write    (MEM_WB_write),
        .IF_ID_flush     (IF_ID_flush),
        .ID_EX_flush     (ID_EX_flush),
        .MEM_WB_flush    (MEM_WB_flush),
        .mem_error       (mem_error),
        .stall_cycles    (stall_cycles)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic mr, input logic [4:0] rd,
                          input logic br, input logic mop, input logic rdy);
        rs1_ID = rs1; rs2_ID = rs2; use_rs1_ID = u1; use_rs2_ID = u2;
        MemRead_EX = mr; RD_EX = rd; branch_taken_EX = br;
        mem_op_MEM = mop; dmem_ready = rdy;
    endtask

    // One clock: predict from the hazard rules, compare on the falling edge, advance the model.
    task automatic run_cycle(input string tag);
        logic       lu, ms, errv;
        logic [7:0] exp_ctl;
        lu = MemRead_EX && (RD_EX != 5'd0) &&
             ((use_rs1_ID && rs1_ID == RD_EX) || (use_rs2_ID && rs2_ID == RD_EX));
        errv = !reset && m_err;
        if (reset)       ms = mem_op_MEM && !dmem_ready;
        else if (m_err)  ms = 1'b0;
        else if (m_out)  ms = !dmem_ready;
        else             ms = mem_op_MEM && !dmem_ready;
        if (errv)                 exp_ctl = C_ERR;
        else if (ms)              exp_ctl = C_MEM;
        else if (branch_taken_EX) exp_ctl = C_BR;
        else if (lu)              exp_ctl = C_LU;
        else                      exp_ctl = C_NORM;
        @(negedge clk);
        last_ctl   = ctl;
        last_stall = stall_cycles;
        last_merr  = mem_error;
        chk({tag, ".ctl"}, 32'(ctl), 32'(exp_ctl));
        chk({tag, ".mem_error"}, 32'(mem_error), 32'(errv));
        chk({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(m_stall));
        @(posedge clk);
        if (reset) begin
            m_err = 0; m_out = 0; m_consec = 0; m_stall = 0;
        end else if (!m_err) begin
            if ((ms || (lu && !branch_taken_EX)) && m_stall < CNT_MAX) m_stall++;
            if (ms) begin
                m_consec++;
                m_out = 1;
                if (m_consec >= TIMEOUT) m_err = 1;
            end else begin
                m_consec = 0;
                m_out = 0;
            end
        end
        #1;
    endtask

    task automatic idle_in();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_in();
        run_cycle("reset");
        reset = 1'b0;
    endtask

    initial begin
        tbl[0] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, C_LU};
        tbl[1] = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, C_NORM};
        tbl[2] = '{5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, C_NORM};
        tbl[3] = '{5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, C_LU};
        tbl[4] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, C_NORM};
        tbl[5] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, C_BR};
        tbl[6] = '{5'd6, 5'd6, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1, 1'b1, C_LU};
        tbl[7] = '{5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, C_BR};

        m_err = 0; m_out = 0; m_consec = 0; m_stall = 0;
        reset = 1'b1;
        idle_in();
        @(posedge clk);
        #1;
        run_cycle("rst_state");
        chk("rst_state.ctl_const", 32'(last_ctl), 32'(C_NORM));
        chk("rst_state.stall_zero", 32'(last_stall), 32'd0);
        reset = 1'b0;

        // Table vectors in RUN state
        for (int i = 0; i < 8; i++) begin
            set_in(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].mr,
                   tbl[i].rd, tbl[i].br, tbl[i].mop, tbl[i].rdy);
            run_cycle($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.exp", i), 32'(last_ctl), 32'(tbl[i].exp));
        end
        // entries 0, 3 and 6 each stalled one cycle; the branch-masked one did not
        idle_in();
        run_cycle("tbl_tail");
        chk("tbl.stall_total", 32'(last_stall), 32'd3);

        // Memory wait: three not-ready cycles, release on the fourth
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_cycle("memwait");
            chk($sformatf("memwait%0d.frozen", i), 32'(last_ctl), 32'(C_MEM));
        end
        dmem_ready = 1'b1;
        run_cycle("memwait_rel");
        chk("memwait.release", 32'(last_ctl), 32'(C_NORM));
        idle_in();
        run_cycle("memwait_after");
        chk("memwait.stall_total", 32'(last_stall), 32'd6);

        // Branch deferred behind a two-cycle memory stall
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        run_cycle("defbr0");
        chk("defbr0.no_flush", 32'(last_ctl), 32'(C_MEM));
        mem_op_MEM = 1'b0;
        run_cycle("defbr1");
        chk("defbr1.no_flush", 32'(last_ctl), 32'(C_MEM));
        dmem_ready = 1'b1;
        run_cycle("defbr_rel");
        chk("defbr.release_flush", 32'(last_ctl), 32'(C_BR));
        idle_in();
        run_cycle("defbr_after");
        chk("defbr.after", 32'(last_ctl), 32'(C_NORM));

        // Watchdog timeout
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < TIMEOUT; i++) run_cycle("tmo_wait");
        chk("tmo.last_wait", 32'(last_ctl), 32'(C_MEM));
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) run_cycle("tmo_err");
        chk("tmo.error_ctl", 32'(last_ctl), 32'(C_ERR));
        chk("tmo.mem_error", 32'(last_merr), 32'd1);
        chk("tmo.stall_frozen", 32'(last_stall), 32'd12);
        do_reset();
        idle_in();
        run_cycle("tmo_post");
        chk("tmo.post_reset_err", 32'(last_merr), 32'd0);
        chk("tmo.post_reset_cnt", 32'(last_stall), 32'd0);

        // Reset asserted in the middle of a memory wait
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        run_cycle("rmid0");
        run_cycle("rmid1");
        reset = 1'b1;
        mem_op_MEM = 1'b0;
        run_cycle("rmid_rst");
        chk("rmid.during_reset", 32'(last_ctl), 32'(C_NORM));
        reset = 1'b0;
        run_cycle("rmid_after");
        chk("rmid.run_state", 32'(last_ctl), 32'(C_NORM));
        chk("rmid.cnt_zero", 32'(last_stall), 32'd0);

        // Counter saturation
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < CNT_MAX + 5; i++) run_cycle("sat");
        idle_in();
        run_cycle("sat_end");
        chk("sat.all_ones", 32'(last_stall), 32'(CNT_MAX));
        do_reset();

        // Randomized stimulus against the model
        for (int i = 0; i < 600; i++) begin
            reset = m_err ? 1'b1 : ($urandom_range(0, 99) < 2);
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 35),
                   ($urandom_range(0, 99) < 55));
            run_cycle("rand");
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
